speed_stats_ctrl: RTL and testbench

Sequencing controller for the bike computer's maximum-speed tracker. It qualifies incoming speed samples, so that only samples taken while the bike is genuinely moving reach the tracker. It issues the tracker's enable and clear strobes and decodes the trip button into a short-press mode step and a long-press trip clear. It sits between the speed-calculation block and the max-speed register, and feeds the display mode logic.

---
 rtl/speed_stats_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_speed_stats_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_stats_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : speed_stats_ctrl                                                |
// | Purpose  : Qualifies speed samples for the max-speed tracker, issues its    |
// |            enable/clear strobes and decodes the trip button into a         |
// |            short-press mode step and a long-press trip clear.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module speed_stats_ctrl #(
  parameter int WIDTH       = 7,
  parameter int SETTLE_N    = 3,
  parameter int STOP_TO     = 3000,
  parameter int HOLD_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             r,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] speed,
  input  logic             btn,
  output logic [WIDTH-1:0] speed_q,
  output logic             max_en,
  output logic             max_clr,
  output logic             mode_step,
  output logic             moving,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSE  = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  localparam int c_settle_w = $clog2(SETTLE_N + 1);
  localparam int c_to_w     = $clog2(STOP_TO + 1);
  localparam int c_hold_w   = $clog2(HOLD_CYCLES + 1);

  // With a single-sample settle requirement the first nonzero sample is
  // already qualified, so IDLE/PAUSE jump straight to RUN.
  localparam bit                  c_direct_run  = (SETTLE_N == 1);
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_N - 1);
  localparam logic [c_to_w-1:0]   c_to_last     = c_to_w'(STOP_TO - 1);
  localparam logic [c_to_w-1:0]   c_to_max      = c_to_w'(STOP_TO);
  localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_max    = c_hold_w'(HOLD_CYCLES);

  state_t                r_state;
  state_t                r_origin;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_to_w-1:0]     r_to_cnt;
  logic [c_hold_w-1:0]   r_hold_cnt;
  logic                  r_latch;
  logic [WIDTH-1:0]      r_speed_q;
  logic                  r_max_en;
  logic                  r_max_clr;
  logic                  r_mode_step;
  logic                  r_moving;

  logic w_nz_sample;
  logic w_zero_sample;
  logic w_hold_hit;
  logic w_release;
  logic w_timeout;
  logic w_to_active;

  assign w_nz_sample   = sample_valid && (|speed);
  assign w_zero_sample = sample_valid && !(|speed);
  // The hold count reaches its limit on this edge; the latch keeps one press
  // from clearing twice.
  assign w_hold_hit    = btn && !r_latch && (r_hold_cnt == c_hold_last);
  assign w_release     = !btn && (r_hold_cnt != '0);
  assign w_to_active   = (r_state == S_SETTLE) || (r_state == S_RUN);
  // The quiet-cycle counter reaches STOP_TO on this edge.
  assign w_timeout     = w_to_active && !sample_valid && (r_to_cnt == c_to_last);

  // Button hold counter, long-press latch and short-press mode step.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_hold_cnt  <= '0;
      r_latch     <= 1'b0;
      r_mode_step <= 1'b0;
    end else begin
      r_mode_step <= w_release && !r_latch;
      if (btn) begin
        if (r_hold_cnt != c_hold_max) r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
      if (w_hold_hit) r_latch <= 1'b1;
      else if (!btn)  r_latch <= 1'b0;
    end
  end

  // Main sequencing FSM with its settle/timeout counters and tracker strobes.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state      <= S_IDLE;
      r_origin     <= S_IDLE;
      r_settle_cnt <= '0;
      r_to_cnt     <= '0;
      r_speed_q    <= '0;
      r_max_en     <= 1'b0;
      r_max_clr    <= 1'b0;
      r_moving     <= 1'b0;
    end else begin
      r_max_en  <= 1'b0;
      r_max_clr <= 1'b0;
      if (w_hold_hit) begin
        // Long press wins over anything else this cycle, including a sample.
        r_state      <= S_CLEAR;
        r_max_clr    <= 1'b1;
        r_moving     <= 1'b0;
        r_settle_cnt <= '0;
        r_to_cnt     <= '0;
      end else begin
        case (r_state)
          S_CLEAR: begin
            r_state  <= S_IDLE;
            r_moving <= 1'b0;
            r_to_cnt <= '0;
          end
          S_IDLE, S_PAUSE: begin
            r_to_cnt <= '0;
            if (w_nz_sample) begin
              r_origin <= r_state;
              if (c_direct_run) begin
                r_state   <= S_RUN;
                r_moving  <= 1'b1;
                r_max_en  <= 1'b1;
                r_speed_q <= speed;
              end else begin
                r_state      <= S_SETTLE;
                r_settle_cnt <= c_settle_w'(1);
              end
            end
          end
          S_SETTLE: begin
            if (w_nz_sample) begin
              r_to_cnt <= '0;
              if (r_settle_cnt == c_settle_last) begin
                r_state      <= S_RUN;
                r_moving     <= 1'b1;
                r_max_en     <= 1'b1;
                r_speed_q    <= speed;
                r_settle_cnt <= '0;
              end else begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
              end
            end else if (w_zero_sample || w_timeout) begin
              r_state      <= r_origin;
              r_settle_cnt <= '0;
              r_to_cnt     <= '0;
            end else if (r_to_cnt != c_to_max) begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (w_nz_sample) begin
              r_max_en  <= 1'b1;
              r_speed_q <= speed;
              r_to_cnt  <= '0;
            end else if (w_zero_sample || w_timeout) begin
              r_state  <= S_PAUSE;
              r_moving <= 1'b0;
              r_to_cnt <= '0;
            end else if (r_to_cnt != c_to_max) begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_moving <= 1'b0;
            r_to_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign speed_q   = r_speed_q;
  assign max_en    = r_max_en;
  assign max_clr   = r_max_clr;
  assign mode_step = r_mode_step;
  assign moving    = r_moving;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_speed_stats_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_speed_stats_ctrl                                             |
// | Purpose  : Self-checking bench for speed_stats_ctrl: directed scenarios     |
// |            plus randomized traffic against a timestamp-based model.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_speed_stats_ctrl;

  localparam int WIDTH       = 7;
  localparam int SETTLE_N    = 3;
  localparam int STOP_TO     = 3000;
  localparam int HOLD_CYCLES = 2000;

  localparam int M_IDLE   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_RUN    = 2;
  localparam int M_PAUSE  = 3;
  localparam int M_CLEAR  = 4;

  logic             clk;
  logic             r;
  logic             sample_valid;
  logic [WIDTH-1:0] speed;
  logic             btn;
  logic [WIDTH-1:0] speed_q;
  logic             max_en;
  logic             max_clr;
  logic             mode_step;
  logic             moving;
  logic [2:0]       state;

  int n_err;
  int n_chk;

  // Reference model: timestamps rather than counters
  int               cyc;
  int               m_st;
  int               m_from;
  int               m_streak;
  int               m_last_sample;
  bit               m_pressing;
  int               m_press_start;
  bit               m_long;
  logic [WIDTH-1:0] m_q;
  bit               e_en;
  bit               e_clr;
  bit               e_step;

  speed_stats_ctrl #(
    .WIDTH(WIDTH), .SETTLE_N(SETTLE_N), .STOP_TO(STOP_TO), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .r(r), .sample_valid(sample_valid), .speed(speed), .btn(btn),
    .speed_q(speed_q), .max_en(max_en), .max_clr(max_clr), .mode_step(mode_step),
    .moving(moving), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] dut_vec();
    return {state, speed_q, max_en, max_clr, mode_step, moving};
  endfunction

  function automatic logic [13:0] exp_vec();
    return {3'(m_st), m_q, e_en, e_clr, e_step, (m_st == M_RUN)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_st = M_IDLE; m_from = M_IDLE; m_streak = 0; m_last_sample = 0;
    m_pressing = 0; m_press_start = 0; m_long = 0; m_q = '0;
    e_en = 0; e_clr = 0; e_step = 0;
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_edge(input logic sv, input logic [WIDTH-1:0] sp, input logic b);
    bit hit, nz, tmo;
    cyc++;
    e_en = 0; e_clr = 0; e_step = 0; hit = 0;
    // Button: press duration measured from the first edge it was seen high.
    if (b) begin
      if (!m_pressing) begin
        m_pressing = 1; m_press_start = cyc; m_long = 0;
      end
      if (!m_long && (cyc - m_press_start + 1 == HOLD_CYCLES)) begin
        hit = 1; m_long = 1;
      end
    end else if (m_pressing) begin
      if (!m_long) e_step = 1;
      m_pressing = 0; m_long = 0;
    end
    nz  = sv && (sp != 0);
    tmo = (m_st == M_SETTLE || m_st == M_RUN) && !sv && (cyc - m_last_sample == STOP_TO);
    if (sv) m_last_sample = cyc;
    if (hit) begin
      m_st = M_CLEAR; e_clr = 1; m_streak = 0;
    end else begin
      case (m_st)
        M_CLEAR: m_st = M_IDLE;
        M_IDLE, M_PAUSE: if (nz) begin
          m_from = m_st; m_streak = 1;
          if (m_streak == SETTLE_N) begin m_st = M_RUN; e_en = 1; m_q = sp; end
          else m_st = M_SETTLE;
        end
        M_SETTLE: if (nz) begin
          m_streak++;
          if (m_streak == SETTLE_N) begin m_st = M_RUN; e_en = 1; m_q = sp; m_streak = 0; end
        end else if (sv || tmo) begin
          m_st = m_from; m_streak = 0;
        end
        M_RUN: if (nz) begin e_en = 1; m_q = sp; end
               else if (sv || tmo) m_st = M_PAUSE;
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  // One clock: drive inputs, let the edge happen, check every output.
  task automatic step(input logic sv, input logic [WIDTH-1:0] sp, input logic b);
    sample_valid = sv; speed = sp; btn = b;
    @(posedge clk);
    model_edge(sv, sp, b);
    #1;
    chk("outs", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic do_reset();
    sample_valid = 1'b0; speed = '0; btn = 1'b0;
    r = 1'b0;
    #1;
    chk("rst_outs", 32'(dut_vec()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    r = 1'b1;
    model_reset();
  endtask

  task automatic rnd_sample(output logic sv, output logic [WIDTH-1:0] sp);
    sv = ($urandom_range(0, 2) == 0);
    sp = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(1, 127));
  endtask

  initial begin
    logic             sv;
    logic [WIDTH-1:0] sp;
    int               len;
    n_err = 0; n_chk = 0;
    sample_valid = 1'b0; speed = '0; btn = 1'b0; r = 1'b0;
    model_reset();

    // Reset state
    do_reset();

    // Settle then run: 20, 25, 30, 28, 0
    step(1'b1, 7'd20, 1'b0); chk("en_20", 32'(max_en), 32'd0);
    step(1'b1, 7'd25, 1'b0); chk("en_25", 32'(max_en), 32'd0);
    chk("st_settle", 32'(state), 32'd1);
    step(1'b1, 7'd30, 1'b0); chk("en_30", 32'(max_en), 32'd1);
    chk("q_30", 32'(speed_q), 32'd30); chk("mov_30", 32'(moving), 32'd1);
    step(1'b1, 7'd28, 1'b0); chk("q_28", 32'(speed_q), 32'd28);
    chk("en_28", 32'(max_en), 32'd1);
    step(1'b1, 7'd0, 1'b0); chk("st_pause", 32'(state), 32'd3);
    chk("mov_fall", 32'(moving), 32'd0); chk("en_zero", 32'(max_en), 32'd0);
    chk("q_hold", 32'(speed_q), 32'd28);

    // Zero sample aborts settle back to IDLE
    do_reset();
    step(1'b1, 7'd15, 1'b0);
    step(1'b1, 7'd0, 1'b0); chk("st_abort", 32'(state), 32'd0);
    step(1'b1, 7'd15, 1'b0);
    step(1'b1, 7'd15, 1'b0); chk("en_pre", 32'(max_en), 32'd0);
    step(1'b1, 7'd15, 1'b0); chk("st_run15", 32'(state), 32'd2);
    chk("en_15", 32'(max_en), 32'd1);

    // Timeout in RUN
    for (int i = 1; i <= STOP_TO; i++) begin
      step(1'b0, '0, 1'b0);
      if (i == STOP_TO - 1) chk("to_before", 32'(state), 32'd2);
    end
    chk("to_pause", 32'(state), 32'd3);
    chk("to_en", 32'(max_en), 32'd0);

    // Short press
    repeat (10) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("short_step", 32'(mode_step), 32'd1);
    chk("short_state", 32'(state), 32'd3);
    step(1'b0, '0, 1'b0);
    chk("short_once", 32'(mode_step), 32'd0);

    // Long press
    for (int i = 1; i <= 2500; i++) begin
      step(1'b0, '0, 1'b1);
      if (i == HOLD_CYCLES) begin
        chk("long_clr", 32'(max_clr), 32'd1);
        chk("long_st", 32'(state), 32'd4);
      end
      if (i == HOLD_CYCLES + 1) chk("long_idle", 32'(state), 32'd0);
    end
    step(1'b0, '0, 1'b0);
    chk("long_nostep", 32'(mode_step), 32'd0);

    // Long press colliding with a sample in RUN
    repeat (3) step(1'b1, 7'd50, 1'b0);
    chk("coll_run", 32'(state), 32'd2);
    repeat (HOLD_CYCLES - 1) step(1'b0, '0, 1'b1);
    step(1'b1, 7'd40, 1'b1);
    chk("coll_clr", 32'(max_clr), 32'd1);
    chk("coll_en", 32'(max_en), 32'd0);
    chk("coll_q", 32'(speed_q), 32'd50);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Randomized traffic
    for (int s = 0; s < 16; s++) begin
      case ($urandom_range(0, 3))
        0: repeat (80) begin rnd_sample(sv, sp); step(sv, sp, 1'b0); end
        1: begin
          len = $urandom_range(50, 3200);
          repeat (len) step(1'b0, '0, 1'b0);
        end
        2: begin
          len = $urandom_range(1, 40);
          repeat (len) begin rnd_sample(sv, sp); step(sv, sp, 1'b1); end
          step(1'b0, '0, 1'b0);
        end
        default: begin
          len = $urandom_range(HOLD_CYCLES - 5, HOLD_CYCLES + 60);
          repeat (len) begin rnd_sample(sv, sp); step(sv, sp, 1'b1); end
          step(1'b0, '0, 1'b0);
        end
      endcase
    end

    // Asynchronous reset right after a tracked sample
    do_reset();
    step(1'b1, 7'd10, 1'b0);
    step(1'b1, 7'd11, 1'b0);
    step(1'b1, 7'd12, 1'b0);
    step(1'b1, 7'd33, 1'b0);
    chk("arst_pre_en", 32'(max_en), 32'd1);
    #2;
    r = 1'b0;
    #1;
    chk("arst_outs", 32'(dut_vec()), 32'd0);
    chk("arst_en", 32'(max_en), 32'd0);
    sample_valid = 1'b0; speed = '0; btn = 1'b0;
    @(negedge clk);
    r = 1'b1;
    model_reset();
    step(1'b0, '0, 1'b0);
    chk("arst_idle", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
